bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-add-3 (double-dabble). It produces the packed 12-bit BCD bus consumed by the seg7 display multiplexer. The binary counter presents a value and pulses start. The converter returns three BCD digits after BIN_W cycles and holds them stable for the display between conversions.

---
 rtl/bcd_pkg.sv | 43 ++++
 rtl/bcd_add3.sv | 24 ++
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter.
//   - state_e       : converter FSM states (IDLE, SHIFT)
//   - DEF_BIN_W     : default binary input width
//   - DEF_DIG       : default number of BCD digits
//   - BCD_W         : packed BCD bus width of the default configuration
//   - ONES/TENS/HUNDREDS : digit positions inside the packed BCD bus
//   - pow10 / bcd_fits   : elaboration helpers for the digit-count check
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_BIN_W = 8;
  localparam int DEF_DIG   = 3;
  localparam int BCD_W     = 4 * DEF_DIG;

  localparam int ONES      = 0;
  localparam int TENS      = 1;
  localparam int HUNDREDS  = 2;

  // 10^n as a 64-bit value; only evaluated at elaboration time.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

  // True when dig decimal digits can hold the largest bin_w-bit value.
  function automatic bit bcd_fits(input int bin_w, input int dig);
    longint unsigned max_bin;
    max_bin = (64'd1 << bin_w) - 64'd1;
    return (pow10(dig) > max_bin);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble correction for one BCD digit: any digit of
//   5 or more is bumped by 3 so that the following left shift carries
//   correctly into the next decimal digit.
//   Ports:
//     digit_i  in  4  current BCD digit
//     digit_o  out 4  corrected digit (digit_i >= 5 ? digit_i + 3 : digit_i)
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Per-digit add-3; no carry leaves the digit because inputs never exceed 9.
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3). A start in IDLE
//   captures bin; BIN_W shift steps later the packed BCD result is loaded
//   into bcd together with a one-cycle done pulse. bcd holds the previous
//   result during a conversion so the display never shows partial digits.
//   Ports:
//     clk_50MHz  in  1        system clock, rising edge
//     reset_n    in  1        asynchronous active-low reset
//     bin        in  BIN_W    binary value, sampled on an accepted start
//     start      in  1        conversion request (pulse or level)
//     busy       out 1        conversion in progress
//     done       out 1        one-cycle pulse, bcd updated in same cycle
//     bcd        out 4*DIG    packed BCD, [3:0] ones, [7:4] tens, ...
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int DIG   = DEF_DIG
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [4*DIG-1:0] bcd
);

  localparam int OUT_W = 4 * DIG;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  // Refuse configurations whose digits cannot represent 2^BIN_W-1.
  if (!bcd_fits(BIN_W, DIG)) begin : g_width_check
    $error("bin2bcd_seq: DIG=%0d digits cannot hold a %0d-bit value", DIG, BIN_W);
  end

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [BIN_W-1:0]   bin_work_q, bin_work_d;
  logic [OUT_W-1:0]   bcd_work_q, bcd_work_d;
  logic [OUT_W-1:0]   bcd_q,      bcd_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  logic [OUT_W-1:0]   bcd_adj_s;
  logic [OUT_W-1:0]   bcd_shift_s;
  logic [BIN_W-1:0]   bin_shift_s;
  logic               last_step_s;

  for (genvar g = 0; g < DIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_work_q[4*g +: 4]),
      .digit_o (bcd_adj_s[4*g +: 4])
    );
  end

  // One double-dabble step: corrected digits shifted left, binary MSB enters the ones LSB.
  always_comb begin
    bcd_shift_s                 = {bcd_adj_s[OUT_W-2:0], 1'b0};
    bcd_shift_s[4*ONES]         = bin_work_q[BIN_W-1];
    bin_shift_s                 = {bin_work_q[BIN_W-2:0], 1'b0};
    last_step_s                 = (count_q == LAST_STEP);
  end

  // FSM next-state, datapath and output next-values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bin_work_d = bin_work_q;
    bcd_work_d = bcd_work_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_work_d = bin;
          bcd_work_d = '0;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end else begin
          busy_d     = 1'b0;
        end
      end
      SHIFT: begin
        bin_work_d = bin_shift_s;
        bcd_work_d = bcd_shift_s;
        count_d    = count_q + CNT_W'(1);
        if (last_step_s) begin
          bcd_d   = bcd_shift_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, work and output registers with asynchronous reset.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      bin_work_q <= '0;
      bcd_work_q <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bin_work_q <= bin_work_d;
      bcd_work_q <= bcd_work_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
